banco_reg_param: RTL and testbench



---
 rtl/banco_reg_param_pkg.sv | 18 +
 rtl/banco_reg_param_if.sv | 39 +++
 rtl/placar_pendentes.sv | 38 +++
 rtl/banco_reg_param.sv | 111 +++++++++++
 tb/tb_banco_reg_param.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/banco_reg_param_pkg.sv
// Shared definitions for the parametrised register file.
// Provides the clear-sequencer state type, the default parameter values and
// the helper that derives the address width from the register count.
package pkg_banco_reg;

    typedef enum logic [0:0] {
        LIMPA,
        ATIVO
    } estado_t;

    localparam int unsigned LARGURA_PADRAO  = 32;
    localparam int unsigned NUM_REGS_PADRAO = 64;

    function automatic int unsigned end_largura(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/banco_reg_param_if.sv
// Bus between the control unit and the register file.
// master: control unit (drives write/read/reserve requests, receives data,
//         pending bits and pronto).
// slave : register file.
interface banco_reg_param_if
    import pkg_banco_reg::*;
#(
    parameter int unsigned LARGURA  = LARGURA_PADRAO,
    parameter int unsigned NUM_REGS = NUM_REGS_PADRAO
) ();

    localparam int unsigned END = end_largura(NUM_REGS);

    logic               reg_write;
    logic [END-1:0]     reg_escrita;
    logic [LARGURA-1:0] escreve_dado;
    logic [END-1:0]     reg_leitura1;
    logic [END-1:0]     reg_leitura2;
    logic               reserva;
    logic [END-1:0]     reg_reserva;
    logic [LARGURA-1:0] dado1;
    logic [LARGURA-1:0] dado2;
    logic               pendente1;
    logic               pendente2;
    logic               pronto;

    modport master (
        output reg_write, reg_escrita, escreve_dado, reg_leitura1, reg_leitura2,
               reserva, reg_reserva,
        input  dado1, dado2, pendente1, pendente2, pronto
    );

    modport slave (
        input  reg_write, reg_escrita, escreve_dado, reg_leitura1, reg_leitura2,
               reserva, reg_reserva,
        output dado1, dado2, pendente1, pendente2, pronto
    );

endinterface

// File: rtl/placar_pendentes.sv
// Per-register pending scoreboard.
// Ports: clock/reset (sync, active-high, clears every bit); i_set/i_set_end
// mark a register pending; i_limpa/i_limpa_end clear one; i_leitura1/2 select
// the bits shown on o_pend1/2 (combinational).
module placar_pendentes
    import pkg_banco_reg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_PADRAO,
    localparam int unsigned END = end_largura(NUM_REGS)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           i_set,
    input  logic [END-1:0] i_set_end,
    input  logic           i_limpa,
    input  logic [END-1:0] i_limpa_end,
    input  logic [END-1:0] i_leitura1,
    input  logic [END-1:0] i_leitura2,
    output logic           o_pend1,
    output logic           o_pend2
);

    logic [NUM_REGS-1:0] r_pend;

    // Set is applied after clear so a reserve beats a same-cycle write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            if (i_limpa) r_pend[i_limpa_end] <= 1'b0;
            if (i_set)   r_pend[i_set_end]   <= 1'b1;
        end
    end

    assign o_pend1 = r_pend[i_leitura1];
    assign o_pend2 = r_pend[i_leitura2];

endmodule

// File: rtl/banco_reg_param.sv
// Parametrised MIPS register file: two combinational read ports, one clocked
// write port, optional hardwired zero register, optional write-to-read bypass,
// a post-reset clear sequencer and a per-register pending scoreboard.
// Ports: clock, reset (sync, active-high, restarts the clear sequence);
// bus (slave modport) carrying write/read/reserve requests, data, pending
// bits and pronto.
module banco_reg_param
    import pkg_banco_reg::*;
#(
    parameter int unsigned LARGURA   = LARGURA_PADRAO,
    parameter int unsigned NUM_REGS  = NUM_REGS_PADRAO,
    parameter bit          ZERO_FIXO = 1'b1,
    parameter bit          BYPASS    = 1'b1
) (
    input logic               clock,
    input logic               reset,
    banco_reg_param_if.slave  bus
);

    localparam int unsigned    END    = end_largura(NUM_REGS);
    localparam logic [END-1:0] ULTIMO = END'(NUM_REGS - 1);

    estado_t            r_estado;
    estado_t            w_estado_prox;
    logic [END-1:0]     r_contador;
    logic [LARGURA-1:0] r_regs [NUM_REGS];

    logic               w_ativo;
    logic               w_escreve;
    logic               w_reserva;
    logic [END-1:0]     w_end [2];
    logic               w_pend_placar [2];
    logic [LARGURA-1:0] w_dado [2];
    logic               w_pend [2];

    assign w_ativo = (r_estado == ATIVO);

    // Effective write/reserve: only in ATIVO, never while resetting, never to r0
    // when it is hardwired.
    assign w_escreve = w_ativo && !reset && bus.reg_write &&
                       !(ZERO_FIXO && (bus.reg_escrita == '0));
    assign w_reserva = w_ativo && !reset && bus.reserva &&
                       !(ZERO_FIXO && (bus.reg_reserva == '0));

    always_comb begin
        w_estado_prox = r_estado;
        if ((r_estado == LIMPA) && (r_contador == ULTIMO)) w_estado_prox = ATIVO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= LIMPA;
            r_contador <= '0;
        end else begin
            r_estado <= w_estado_prox;
            if (r_estado == LIMPA) r_contador <= r_contador + END'(1);
        end
    end

    // Storage has no reset of its own: the clear sequence zeroes it one word
    // per cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_estado == LIMPA) begin
                r_regs[r_contador] <= '0;
            end else if (w_escreve) begin
                r_regs[bus.reg_escrita] <= bus.escreve_dado;
            end
        end
    end

    placar_pendentes #(
        .NUM_REGS (NUM_REGS)
    ) u_placar (
        .clock       (clock),
        .reset       (reset),
        .i_set       (w_reserva),
        .i_set_end   (bus.reg_reserva),
        .i_limpa     (w_escreve),
        .i_limpa_end (bus.reg_escrita),
        .i_leitura1  (bus.reg_leitura1),
        .i_leitura2  (bus.reg_leitura2),
        .o_pend1     (w_pend_placar[0]),
        .o_pend2     (w_pend_placar[1])
    );

    assign w_end[0] = bus.reg_leitura1;
    assign w_end[1] = bus.reg_leitura2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_dado[p] = r_regs[w_end[p]];
            w_pend[p] = w_pend_placar[p];
            if (BYPASS && w_escreve && (w_end[p] == bus.reg_escrita)) begin
                w_dado[p] = bus.escreve_dado;
                w_pend[p] = w_reserva && (bus.reg_reserva == bus.reg_escrita);
            end
            if (!w_ativo || (ZERO_FIXO && (w_end[p] == '0))) begin
                w_dado[p] = '0;
                w_pend[p] = 1'b0;
            end
        end
    end

    assign bus.dado1     = w_dado[0];
    assign bus.dado2     = w_dado[1];
    assign bus.pendente1 = w_pend[0];
    assign bus.pendente2 = w_pend[1];
    assign bus.pronto    = w_ativo;

endmodule

// File: tb/tb_banco_reg_param.sv
// Bench for banco_reg_param: a default instance (bypass on), a bypass-off
// instance sharing the same stimulus, and a 16-bit x 8 register instance.
module tb_banco_reg_param;

    logic clock = 1'b0;
    logic reset;
    logic reset_s;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    banco_reg_param_if #(.LARGURA(32), .NUM_REGS(64)) bm ();
    banco_reg_param_if #(.LARGURA(32), .NUM_REGS(64)) bnb ();
    banco_reg_param_if #(.LARGURA(16), .NUM_REGS(8))  bs ();

    assign bnb.reg_write    = bm.reg_write;
    assign bnb.reg_escrita  = bm.reg_escrita;
    assign bnb.escreve_dado = bm.escreve_dado;
    assign bnb.reg_leitura1 = bm.reg_leitura1;
    assign bnb.reg_leitura2 = bm.reg_leitura2;
    assign bnb.reserva      = bm.reserva;
    assign bnb.reg_reserva  = bm.reg_reserva;

    banco_reg_param #(.LARGURA(32), .NUM_REGS(64), .ZERO_FIXO(1'b1), .BYPASS(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bm)
    );

    banco_reg_param #(.LARGURA(32), .NUM_REGS(64), .ZERO_FIXO(1'b1), .BYPASS(1'b0)) dut_nb (
        .clock (clock),
        .reset (reset),
        .bus   (bnb)
    );

    banco_reg_param #(.LARGURA(16), .NUM_REGS(8), .ZERO_FIXO(1'b1), .BYPASS(1'b1)) dut_s (
        .clock (clock),
        .reset (reset_s),
        .bus   (bs)
    );

    // Reference model of the 64x32 file: contents, pending set, and the number
    // of clock edges still needed before the file becomes usable.
    logic [31:0] m_regs [64];
    bit          m_pend [64];
    int          m_clear = 64;

    task automatic clk_edge();
        if (reset) begin
            m_clear = 64;
            for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
        end else if (m_clear > 0) begin
            m_clear--;
            if (m_clear == 0) for (int i = 0; i < 64; i++) m_regs[i] = '0;
        end else begin
            if (bm.reg_write && bm.reg_escrita != 0) begin
                m_regs[bm.reg_escrita] = bm.escreve_dado;
                m_pend[bm.reg_escrita] = 1'b0;
            end
            if (bm.reserva && bm.reg_reserva != 0) m_pend[bm.reg_reserva] = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic void model_read(input bit byp, input logic [5:0] a,
                                       output logic [31:0] d, output logic p);
        d = '0;
        p = 1'b0;
        if (m_clear != 0 || a == 0) return;
        if (byp && bm.reg_write && bm.reg_escrita == a) begin
            d = bm.escreve_dado;
            p = bm.reserva && (bm.reg_reserva == a);
        end else begin
            d = m_regs[a];
            p = m_pend[a];
        end
    endfunction

    function automatic logic [5:0] rand_end();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
        return 6'($urandom_range(0, 7));
    endfunction

    task automatic idle_inputs();
        bm.reg_write = 0; bm.reg_escrita = '0; bm.escreve_dado = '0;
        bm.reg_leitura1 = '0; bm.reg_leitura2 = '0; bm.reserva = 0; bm.reg_reserva = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clk_edge();
        n_checks++;
        if (bm.pronto !== 1'b0 || bm.dado1 !== '0 || bm.dado2 !== '0 ||
            bm.pendente1 !== 1'b0 || bm.pendente2 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: got pronto=%b d1=%h d2=%h p1=%b p2=%b, expected all 0",
                     bm.pronto, bm.dado1, bm.dado2, bm.pendente1, bm.pendente2);
        end
        reset = 1'b0;
        // Write and reserve during the clear must be ignored.
        bm.reg_write = 1; bm.reg_escrita = 6'd5; bm.escreve_dado = 32'hDEADBEEF;
        bm.reserva = 1; bm.reg_reserva = 6'd5; bm.reg_leitura1 = 6'd5;
        for (int i = 1; i <= 64; i++) begin
            clk_edge();
            n_checks++;
            if (bm.pronto !== (i == 64)) begin
                n_errors++;
                $display("FAIL clear_pronto: cycle %0d got %b expected %b", i, bm.pronto, i == 64);
            end
            if (i < 64) begin
                n_checks++;
                if (bm.dado1 !== '0 || bm.pendente1 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL clear_forced: cycle %0d got d1=%h p1=%b expected 0",
                             i, bm.dado1, bm.pendente1);
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < 64; i++) begin
            bm.reg_leitura1 = 6'(i);
            bm.reg_leitura2 = 6'(63 - i);
            #1;
            n_checks++;
            if (bm.dado1 !== 32'h0 || bm.dado2 !== 32'h0 || bm.pendente1 !== 1'b0 ||
                bnb.dado1 !== 32'h0) begin
                n_errors++;
                $display("FAIL cleared_reg: r%0d got d1=%h d2=%h p1=%b nb=%h expected 0",
                         i, bm.dado1, bm.dado2, bm.pendente1, bnb.dado1);
            end
        end
    endtask

    task automatic test_zero();
        bm.reg_write = 1; bm.reg_escrita = 6'd0; bm.escreve_dado = 32'h12345678;
        bm.reg_leitura1 = 6'd0;
        #1;
        n_checks++;
        if (bm.dado1 !== 32'h0) begin
            n_errors++;
            $display("FAIL zero_bypass: got %h expected 0", bm.dado1);
        end
        clk_edge();
        bm.reg_write = 0; bm.reserva = 1; bm.reg_reserva = 6'd0;
        #1;
        n_checks++;
        if (bm.dado1 !== 32'h0 || bnb.dado1 !== 32'h0) begin
            n_errors++;
            $display("FAIL zero_write: got %h/%h expected 0", bm.dado1, bnb.dado1);
        end
        clk_edge();
        bm.reserva = 0;
        #1;
        n_checks++;
        if (bm.pendente1 !== 1'b0 || bnb.pendente1 !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_reserve: got %b/%b expected 0", bm.pendente1, bnb.pendente1);
        end
    endtask

    task automatic test_bypass();
        bm.reg_write = 1; bm.reg_escrita = 6'd9; bm.escreve_dado = 32'hA5A5A5A5;
        bm.reg_leitura1 = 6'd9; bm.reg_leitura2 = 6'd9;
        #1;
        n_checks++;
        if (bm.dado1 !== 32'hA5A5A5A5 || bm.dado2 !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: got %h/%h expected a5a5a5a5", bm.dado1, bm.dado2);
        end
        n_checks++;
        if (bnb.dado1 !== 32'h0 || bnb.dado2 !== 32'h0) begin
            n_errors++;
            $display("FAIL nobypass_old: got %h/%h expected 0", bnb.dado1, bnb.dado2);
        end
        clk_edge();
        bm.reg_write = 0;
        #1;
        n_checks++;
        if (bnb.dado1 !== 32'hA5A5A5A5 || bm.dado1 !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("FAIL write_visible: got nb=%h b=%h expected a5a5a5a5", bnb.dado1, bm.dado1);
        end
    endtask

    task automatic test_scoreboard();
        bm.reserva = 1; bm.reg_reserva = 6'd7; bm.reg_leitura1 = 6'd7;
        clk_edge();
        bm.reserva = 0;
        #1;
        n_checks++;
        if (bm.pendente1 !== 1'b1 || bnb.pendente1 !== 1'b1) begin
            n_errors++;
            $display("FAIL reserve_r7: got %b/%b expected 1", bm.pendente1, bnb.pendente1);
        end
        bm.reg_write = 1; bm.reg_escrita = 6'd7; bm.escreve_dado = 32'd3;
        #1;
        n_checks++;
        if (bm.pendente1 !== 1'b0 || bnb.pendente1 !== 1'b1) begin
            n_errors++;
            $display("FAIL write_pend_same: got b=%b nb=%b expected b=0 nb=1",
                     bm.pendente1, bnb.pendente1);
        end
        clk_edge();
        bm.reg_write = 0;
        #1;
        n_checks++;
        if (bm.pendente1 !== 1'b0 || bnb.pendente1 !== 1'b0 || bnb.dado1 !== 32'd3) begin
            n_errors++;
            $display("FAIL write_clears: got p=%b/%b d=%h expected 0/0/3",
                     bm.pendente1, bnb.pendente1, bnb.dado1);
        end
        bm.reg_write = 1; bm.escreve_dado = 32'h77;
        clk_edge();
        bm.escreve_dado = 32'd3; bm.reserva = 1; bm.reg_reserva = 6'd7;
        #1;
        n_checks++;
        if (bm.pendente1 !== 1'b1 || bm.dado1 !== 32'd3 || bnb.dado1 !== 32'h77) begin
            n_errors++;
            $display("FAIL both_same_cycle: got p=%b d=%h nb=%h expected 1/3/77",
                     bm.pendente1, bm.dado1, bnb.dado1);
        end
        clk_edge();
        idle_inputs();
        bm.reg_leitura1 = 6'd7;
        #1;
        n_checks++;
        if (bm.pendente1 !== 1'b1 || bnb.pendente1 !== 1'b1 || bnb.dado1 !== 32'd3) begin
            n_errors++;
            $display("FAIL reserve_wins: got p=%b/%b d=%h expected 1/1/3",
                     bm.pendente1, bnb.pendente1, bnb.dado1);
        end
    endtask

    task automatic test_random();
        logic [31:0] ed;
        logic        ep;
        for (int c = 0; c < 400; c++) begin
            bm.reg_write    = ($urandom_range(0, 1) == 1);
            bm.reg_escrita  = rand_end();
            bm.escreve_dado = $urandom;
            bm.reserva      = ($urandom_range(0, 2) == 0);
            bm.reg_reserva  = ($urandom_range(0, 1) == 1) ? bm.reg_escrita : rand_end();
            bm.reg_leitura1 = ($urandom_range(0, 1) == 1) ? bm.reg_escrita : rand_end();
            bm.reg_leitura2 = rand_end();
            #1;
            model_read(1'b1, bm.reg_leitura1, ed, ep);
            n_checks++;
            if (bm.dado1 !== ed || bm.pendente1 !== ep) begin
                n_errors++;
                $display("FAIL rand_port1: c%0d got %h/%b expected %h/%b",
                         c, bm.dado1, bm.pendente1, ed, ep);
            end
            model_read(1'b1, bm.reg_leitura2, ed, ep);
            n_checks++;
            if (bm.dado2 !== ed || bm.pendente2 !== ep) begin
                n_errors++;
                $display("FAIL rand_port2: c%0d got %h/%b expected %h/%b",
                         c, bm.dado2, bm.pendente2, ed, ep);
            end
            model_read(1'b0, bm.reg_leitura1, ed, ep);
            n_checks++;
            if (bnb.dado1 !== ed || bnb.pendente1 !== ep) begin
                n_errors++;
                $display("FAIL rand_nb_port1: c%0d got %h/%b expected %h/%b",
                         c, bnb.dado1, bnb.pendente1, ed, ep);
            end
            model_read(1'b0, bm.reg_leitura2, ed, ep);
            n_checks++;
            if (bnb.dado2 !== ed || bnb.pendente2 !== ep) begin
                n_errors++;
                $display("FAIL rand_nb_port2: c%0d got %h/%b expected %h/%b",
                         c, bnb.dado2, bnb.pendente2, ed, ep);
            end
            clk_edge();
        end
        idle_inputs();
    endtask

    task automatic test_reset_after();
        bm.reg_write = 1; bm.reg_escrita = 6'd3; bm.escreve_dado = 32'h55;
        clk_edge();
        bm.reg_write = 0; bm.reserva = 1; bm.reg_reserva = 6'd4;
        clk_edge();
        bm.reserva = 0; bm.reg_leitura1 = 6'd3; bm.reg_leitura2 = 6'd4;
        #1;
        n_checks++;
        if (bm.dado1 !== 32'h55 || bm.pendente2 !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset: got %h/%b expected 55/1", bm.dado1, bm.pendente2);
        end
        reset = 1'b1;
        clk_edge();
        reset = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            clk_edge();
            n_checks++;
            if (bm.pronto !== (i == 64)) begin
                n_errors++;
                $display("FAIL reclear_pronto: cycle %0d got %b expected %b", i, bm.pronto, i == 64);
            end
        end
        n_checks++;
        if (bm.dado1 !== 32'h0 || bm.pendente2 !== 1'b0 || bnb.dado1 !== 32'h0 ||
            bnb.pendente2 !== 1'b0) begin
            n_errors++;
            $display("FAIL reclear_state: got d=%h/%h p=%b/%b expected 0",
                     bm.dado1, bnb.dado1, bm.pendente2, bnb.pendente2);
        end
    endtask

    task automatic test_sweep();
        reset_s = 1'b1;
        clk_edge();
        reset_s = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            clk_edge();
            n_checks++;
            if (bs.pronto !== (i == 8)) begin
                n_errors++;
                $display("FAIL sweep_pronto: cycle %0d got %b expected %b", i, bs.pronto, i == 8);
            end
        end
        bs.reg_write = 1; bs.reg_escrita = 3'd7; bs.escreve_dado = 16'hFFFF;
        bs.reg_leitura1 = 3'd7; bs.reg_leitura2 = 3'd6;
        #1;
        n_checks++;
        if (bs.dado1 !== 16'hFFFF || bs.dado2 !== 16'h0) begin
            n_errors++;
            $display("FAIL sweep_bypass: got %h/%h expected ffff/0", bs.dado1, bs.dado2);
        end
        clk_edge();
        bs.reg_write = 0;
        #1;
        n_checks++;
        if (bs.dado1 !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL sweep_readback: got %h expected ffff", bs.dado1);
        end
    endtask

    initial begin
        reset   = 1'b1;
        reset_s = 1'b1;
        idle_inputs();
        bs.reg_write = 0; bs.reg_escrita = '0; bs.escreve_dado = '0;
        bs.reg_leitura1 = '0; bs.reg_leitura2 = '0; bs.reserva = 0; bs.reg_reserva = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_zero();
        test_bypass();
        test_scoreboard();
        test_random();
        test_reset_after();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
